// File: rtl/percept_pkg.sv
// Shared definitions for the perceptron command line: opcodes, frame field
// widths, serialiser states and the frame-length helper.
package percept_pkg;

   localparam int START_W = 1;
   localparam int OP_W    = 3;

   localparam logic [OP_W-1:0] OP_OUT_DATA1 = 3'h0;
   localparam logic [OP_W-1:0] OP_OUT_DATA2 = 3'h1;
   localparam logic [OP_W-1:0] OP_OUT_RES   = 3'h2;
   localparam logic [OP_W-1:0] OP_LOAD      = 3'h3;
   localparam logic [OP_W-1:0] OP_LOAD_RES  = 3'h4;
   localparam logic [OP_W-1:0] OP_MUL       = 3'h5;
   localparam logic [OP_W-1:0] OP_MUL_ADD   = 3'h6;
   localparam logic [OP_W-1:0] OP_NO_OP     = 3'h7;

   // Serialiser state; TX_SEL is the only state in which a frame may be loaded.
   typedef enum logic [2:0] {TX_SEL, TX_START, TX_ADDR, TX_OP, TX_GAP} tx_state_t;

   // Position inside one neuron's slice of the layer program.
   typedef enum logic [1:0] {PH_LOAD, PH_MAC, PH_OUT} phase_t;

   // Bits on the line for one frame: start bit, address, opcode.
   function automatic int frame_len(input int addr_w);
      return START_W + addr_w + OP_W;
   endfunction

endpackage

// File: rtl/percept_frame_tx.sv
// Frame serialiser: start bit, address MSB first, opcode MSB first, then
// EXEC_GAP idle-high cycles. tx is registered and idles high.
module percept_frame_tx
   import percept_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int EXEC_GAP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] addr,
   input  logic [OP_W-1:0]   op,
   output logic              tx,
   output logic              idle
);

   localparam int SH_W    = frame_len(ADDR_W) - START_W;
   localparam int CNT_MAX = (ADDR_W > EXEC_GAP) ? ADDR_W : EXEC_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   tx_state_t         state, state_n;
   logic [SH_W-1:0]   sh, sh_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              tx_n;

   // State, shifter, counter and line register; reset forces the line high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= TX_SEL;
         sh    <= '0;
         cnt   <= '0;
         tx    <= 1'b1;
      end else begin
         state <= state_n;
         sh    <= sh_n;
         cnt   <= cnt_n;
         tx    <= tx_n;
      end
   end

   // Next state and next line bit; tx_n is the bit shown in the next cycle.
   always_comb begin
      state_n = state;
      sh_n    = sh;
      cnt_n   = cnt;
      tx_n    = 1'b1;
      case (state)
         TX_SEL: begin
            if (load) begin
               state_n = TX_START;
               sh_n    = {addr, op};
               tx_n    = 1'b0;
            end
         end
         TX_START: begin
            state_n = TX_ADDR;
            tx_n    = sh[SH_W-1];
            sh_n    = {sh[SH_W-2:0], 1'b0};
            cnt_n   = '0;
         end
         TX_ADDR: begin
            tx_n = sh[SH_W-1];
            sh_n = {sh[SH_W-2:0], 1'b0};
            if (cnt == CNT_W'(ADDR_W - 1)) begin
               state_n = TX_OP;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         TX_OP: begin
            if (cnt == CNT_W'(OP_W - 1)) begin
               state_n = TX_GAP;
               cnt_n   = '0;
            end else begin
               tx_n  = sh[SH_W-1];
               sh_n  = {sh[SH_W-2:0], 1'b0};
               cnt_n = cnt + 1'b1;
            end
         end
         TX_GAP: begin
            if (cnt == CNT_W'(EXEC_GAP - 1)) begin
               state_n = TX_SEL;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = TX_SEL;
      endcase
   end

   assign idle = (state == TX_SEL);

endmodule

// File: rtl/percept_sequencer.sv
// Command-line bus master: arbitrates single host commands against the fixed
// layer program (LOAD, N_INPUTS x MUL_ADD, OUT_RES per neuron) and hands the
// chosen frame to the serialiser.
//
// Host handshake: cmd_valid/cmd_addr/cmd_op are held by the host until
// cmd_ready is seen high; cmd_ready is high only in the select cycle in which
// that command is taken, and the command is consumed on that clock edge.
module percept_sequencer
   import percept_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int N_NEURONS = 4,
   parameter int N_INPUTS  = 3,
   parameter int BASE_ADDR = 0,
   parameter int EXEC_GAP  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              cmd_valid,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [OP_W-1:0]   cmd_op,
   output logic              cmd_ready,
   output logic              tx,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] cur_addr,
   output logic [OP_W-1:0]   cur_op
);

   localparam int NEU_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
   localparam int IN_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

   phase_t            phase;
   logic [IN_W-1:0]   in_cnt;
   logic [NEU_W-1:0]  neu_cnt;
   logic              busy_q, fin_q, abort_q;
   logic              idle, end_now, take_host, take_prog, load, last_step;
   logic [ADDR_W-1:0] prog_addr, sel_addr;
   logic [OP_W-1:0]   prog_op, sel_op;

   // Arbitration and run status; a run ends only at a select cycle so a frame
   // in flight is never cut short.
   always_comb begin
      end_now   = busy_q & idle & (fin_q | abort_q);
      busy      = busy_q & ~end_now;
      done      = end_now & fin_q & ~abort_q;
      take_host = idle & cmd_valid;
      take_prog = idle & ~cmd_valid & busy & ~abort;
      cmd_ready = take_host;
      load      = take_host | take_prog;
      last_step = (phase == PH_OUT) && (neu_cnt == NEU_W'(N_NEURONS - 1));
      prog_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(neu_cnt);
      case (phase)
         PH_LOAD: prog_op = OP_LOAD;
         PH_MAC:  prog_op = OP_MUL_ADD;
         PH_OUT:  prog_op = OP_OUT_RES;
         default: prog_op = OP_NO_OP;
      endcase
      sel_addr = take_host ? cmd_addr : prog_addr;
      sel_op   = take_host ? cmd_op : prog_op;
   end

   // Run control: start (abort wins), abort latch, last-frame flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= 1'b0;
         fin_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         if (end_now) begin
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            abort_q <= 1'b0;
         end else if (busy_q && abort) begin
            abort_q <= 1'b1;
         end
         if (take_prog && last_step) fin_q <= 1'b1;
         if (start && !busy && !abort) busy_q <= 1'b1;
      end
   end

   // Program counters advance only when a program frame is selected.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase   <= PH_LOAD;
         in_cnt  <= '0;
         neu_cnt <= '0;
      end else if (end_now) begin
         phase   <= PH_LOAD;
         in_cnt  <= '0;
         neu_cnt <= '0;
      end else if (take_prog) begin
         case (phase)
            PH_LOAD: begin
               phase  <= PH_MAC;
               in_cnt <= '0;
            end
            PH_MAC: begin
               if (in_cnt == IN_W'(N_INPUTS - 1)) begin
                  phase  <= PH_OUT;
                  in_cnt <= '0;
               end else begin
                  in_cnt <= in_cnt + 1'b1;
               end
            end
            default: begin
               phase   <= PH_LOAD;
               neu_cnt <= last_step ? '0 : neu_cnt + 1'b1;
            end
         endcase
      end
   end

   // Current-frame fields latch at select and hold until the next select.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_addr <= '0;
         cur_op   <= OP_NO_OP;
      end else if (load) begin
         cur_addr <= sel_addr;
         cur_op   <= sel_op;
      end
   end

   percept_frame_tx #(
      .ADDR_W   (ADDR_W),
      .EXEC_GAP (EXEC_GAP)
   ) u_frame_tx (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .addr (sel_addr),
      .op   (sel_op),
      .tx   (tx),
      .idle (idle)
   );

endmodule

// File: tb/tb_percept_sequencer.sv
// Bench for percept_sequencer: table of host frames checked bit by bit, then
// program runs decoded from tx and compared against an expected frame queue.
module tb_percept_sequencer;

   localparam int W   = 8;
   localparam int NN  = 4;
   localparam int NI  = 3;
   localparam int BA  = 0;
   localparam int G   = 4;
   localparam int FR  = NN * (NI + 2);

   logic         clk, rst, start, abort, cmd_valid;
   logic [W-1:0] cmd_addr;
   logic [2:0]   cmd_op;
   logic         cmd_ready, tx, busy, done;
   logic [W-1:0] cur_addr;
   logic [2:0]   cur_op;

   percept_sequencer #(
      .ADDR_W(W), .N_NEURONS(NN), .N_INPUTS(NI), .BASE_ADDR(BA), .EXEC_GAP(G)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_op(cmd_op),
      .cmd_ready(cmd_ready), .tx(tx), .busy(busy), .done(done),
      .cur_addr(cur_addr), .cur_op(cur_op)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // scoreboard
   logic [W+2:0] exp_q[$];
   int           frame_cnt = 0;
   int           done_cnt  = 0;
   bit           mon_en    = 0;
   logic [W+2:0] mon_got, mon_exp;
   bit           mon_gap;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   // Frame decoder on tx: start bit, W+3 data bits, then G high gap bits.
   always begin
      @(negedge clk);
      if (mon_en && rst === 1'b0 && tx === 1'b0) begin
         mon_got = '0;
         for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            mon_got = {mon_got[W+1:0], tx};
         end
         mon_gap = 1;
         for (int i = 0; i < G; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) mon_gap = 0;
         end
         frame_cnt++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL frame_unexpected: got=%h expected=none", mon_got);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp || !mon_gap) begin
               bad++;
               $display("FAIL frame: got=%h gap_ok=%0d expected=%h gap_ok=1",
                        mon_got, mon_gap, mon_exp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Frame k of the layer program as {addr, op}.
   function automatic logic [W+2:0] prog_frame(input int k);
      int         n, j;
      logic [2:0] op;
      logic [W-1:0] a;
      n  = k / (NI + 2);
      j  = k % (NI + 2);
      op = (j == 0) ? 3'd3 : ((j == NI + 1) ? 3'd2 : 3'd6);
      a  = W'(BA + n);
      return {a, op};
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) tick();
   endtask

   task automatic start_run(output int s);
      tick();
      start = 1'b1;
      s     = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim, output int at);
      at = -1;
      for (int i = 0; i < lim; i++) begin
         if (done === 1'b1) begin
            at = cyc;
            break;
         end
         tick();
      end
   endtask

   task automatic push_prog(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) exp_q.push_back(prog_frame(k));
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [2:0]   op;
      logic [15:0]  line;
   } vec_t;

   vec_t         vecs[4];
   logic [15:0]  got_line;
   bit           hi;
   int           s, d, t_host, base_f, base_d;

   initial begin
      vecs[0] = '{8'h2A, 3'd5, 16'b0_00101010_101_1111};
      vecs[1] = '{8'hFF, 3'd0, 16'b0_11111111_000_1111};
      vecs[2] = '{8'h00, 3'd7, 16'b0_00000000_111_1111};
      vecs[3] = '{8'h81, 3'd2, 16'b0_10000001_010_1111};

      rst = 1'b1; start = 0; abort = 0; cmd_valid = 0; cmd_addr = '0; cmd_op = '0;
      tick(); tick(); tick();
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_cur_addr", cur_addr, 0);
      chk("rst_cur_op", cur_op, 7);
      rst = 1'b0;
      tick();

      // host frames while idle, checked bit by bit on tx
      for (int v = 0; v < 4; v++) begin
         tick();
         cmd_valid = 1'b1; cmd_addr = vecs[v].a; cmd_op = vecs[v].op;
         #1;
         chk("host_cmd_ready", cmd_ready, 1);
         tick();
         cmd_valid = 1'b0;
         got_line = '0;
         for (int i = 0; i < 16; i++) begin
            #1;
            got_line = {got_line[14:0], tx};
            tick();
         end
         chk("host_line", got_line, vecs[v].line);
         chk("host_cur_addr", cur_addr, vecs[v].a);
         chk("host_cur_op", cur_op, vecs[v].op);
      end

      // reset in the middle of a frame's address bits
      tick();
      cmd_valid = 1'b1; cmd_addr = 8'h00; cmd_op = 3'd0;
      tick();
      cmd_valid = 1'b0;
      tick(); tick(); tick();
      #1;
      chk("mid_frame_tx_low", tx, 0);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_tx", tx, 1);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_cur_op", cur_op, 7);
      tick(); tick();
      rst = 1'b0;
      hi = 1;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (tx !== 1'b1) hi = 0;
         tick();
      end
      chk("idle_after_rst", hi, 1);

      mon_en = 1;

      // full program run
      base_f = frame_cnt; base_d = done_cnt;
      push_prog(0, FR - 1);
      start_run(s);
      #1;
      chk("busy_after_start", busy, 1);
      wait_done(400, d);
      chk("run_done_latency", d - s, 341);
      tick();
      #1;
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
      chk("run_frames", frame_cnt - base_f, FR);
      chk("run_done_cnt", done_cnt - base_d, 1);
      chk("run_queue_empty", exp_q.size(), 0);

      // host command injected during program frame 2
      base_f = frame_cnt; base_d = done_cnt;
      push_prog(0, 2);
      start_run(s);
      wait_to(s + 40);
      exp_q.push_back({8'h55, 3'd4});
      cmd_valid = 1'b1; cmd_addr = 8'h55; cmd_op = 3'd4;
      t_host = -1;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (cmd_ready === 1'b1) begin
            t_host = cyc;
            break;
         end
         tick();
      end
      tick();
      cmd_valid = 1'b0;
      chk("inject_select_cycle", t_host - s, 52);
      push_prog(3, FR - 1);
      wait_done(450, d);
      chk("inject_done_latency", d - s, 358);
      tick();
      chk("inject_frames", frame_cnt - base_f, FR + 1);
      chk("inject_done_cnt", done_cnt - base_d, 1);
      chk("inject_queue_empty", exp_q.size(), 0);

      // abort during the address bits of frame 5
      base_f = frame_cnt; base_d = done_cnt;
      push_prog(0, 5);
      start_run(s);
      wait_to(s + 90);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      #1;
      chk("abort_busy_in_frame", busy, 1);
      wait_to(s + 102);
      #1;
      chk("abort_busy_in_gap", busy, 1);
      wait_to(s + 103);
      #1;
      chk("abort_busy_at_sel", busy, 0);
      for (int i = 0; i < 60; i++) tick();
      chk("abort_frames", frame_cnt - base_f, 6);
      chk("abort_no_done", done_cnt - base_d, 0);
      chk("abort_queue_empty", exp_q.size(), 0);

      // start+abort together, then start while busy
      base_f = frame_cnt; base_d = done_cnt;
      tick();
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      #1;
      chk("start_abort_busy", busy, 0);
      for (int i = 0; i < 40; i++) tick();
      chk("start_abort_frames", frame_cnt - base_f, 0);
      push_prog(0, FR - 1);
      start_run(s);
      wait_to(s + 100);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(400, d);
      chk("restart_done_latency", d - s, 341);
      tick();
      chk("restart_frames", frame_cnt - base_f, FR);
      chk("restart_done_cnt", done_cnt - base_d, 1);
      chk("restart_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
